// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, interrupt
// cause codes, register bit positions and the mstatus layout.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

    localparam int IRQ_M_TIMER = 7;
    localparam int IRQ_M_EXT   = 11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MTIP_BIT     = 7;
    localparam int MIP_MEIP_BIT     = 11;

    typedef struct packed {
        logic [23:0] wpri_hi;
        logic        mpie;
        logic [2:0]  wpri_mid;
        logic        mie;
        logic [2:0]  wpri_lo;
    } mstatus_t;

    function automatic mstatus_t mstatus_pack(input logic mie, input logic mpie);
        mstatus_t s;
        s      = '0;
        s.mie  = mie;
        s.mpie = mpie;
        return s;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Parameterizable-width two-flop synchronizer with asynchronous active-low reset.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt/mret trap unit for the 3-stage core.
// Optional 64-bit mcycle counter at 0xB00/0xB80 when CSR_MCYCLE_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic            is_mret,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect,
    output logic [XLEN-1:0] epc_target
);

    localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);

    logic [1:0]      irq_q;
    logic            mtip, meip;
    logic            mst_mie, mst_mpie;
    logic            mie_mtie, mie_meie;
    logic [XLEN-1:0] mtvec, mepc, mcause;
    logic            ext_pend, tmr_pend, irq_pend, irq_take, mret_take, wr_en;
    logic [4:0]      cause_code;
    logic [XLEN-1:0] trap_base, trap_vec;
    logic [XLEN-1:0] mie_word, mip_word;

    irq_sync #(.WIDTH(2)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ext_irq, timer_irq}),
        .q     (irq_q)
    );

    assign mtip = irq_q[0];
    assign meip = irq_q[1];

    // External is checked first so it wins when both sources are pending.
    assign ext_pend   = mie_meie & meip;
    assign tmr_pend   = mie_mtie & mtip;
    assign irq_pend   = mst_mie & (ext_pend | tmr_pend);
    assign irq_take   = irq_pend & instr_valid & ~is_mret;
    assign mret_take  = is_mret & instr_valid;
    assign wr_en      = csr_wr & instr_valid & ~irq_take;
    assign cause_code = ext_pend ? 5'(IRQ_M_EXT) : 5'(IRQ_M_TIMER);
    assign trap_base  = mtvec & ALIGN4;
    assign trap_vec   = mtvec[0] ? trap_base + XLEN'({cause_code, 2'b00}) : trap_base;

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle;

    // A written half takes the new value and suppresses the increment, so no carry either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle <= '0;
        end else if (wr_en && csr_addr == CSR_MCYCLE) begin
            mcycle[31:0] <= csr_wdata[31:0];
        end else if (wr_en && csr_addr == CSR_MCYCLEH) begin
            mcycle[63:32] <= csr_wdata[31:0];
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end
`endif

    always_comb begin
        mie_word               = '0;
        mie_word[MIE_MTIE_BIT] = mie_mtie;
        mie_word[MIE_MEIE_BIT] = mie_meie;
        mip_word               = '0;
        mip_word[MIP_MTIP_BIT] = mtip;
        mip_word[MIP_MEIP_BIT] = meip;
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rd) begin
            case (csr_addr)
                CSR_MSTATUS: csr_rdata = XLEN'(mstatus_pack(mst_mie, mst_mpie));
                CSR_MIE:     csr_rdata = mie_word;
                CSR_MTVEC:   csr_rdata = mtvec;
                CSR_MEPC:    csr_rdata = mepc;
                CSR_MCAUSE:  csr_rdata = mcause;
                CSR_MIP:     csr_rdata = mip_word;
`ifdef CSR_MCYCLE_EN
                CSR_MCYCLE:  csr_rdata = XLEN'(mcycle[31:0]);
                CSR_MCYCLEH: csr_rdata = XLEN'(mcycle[63:32]);
`endif
                default:     csr_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
        end else if (irq_take) begin
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (mret_take) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (wr_en && csr_addr == CSR_MSTATUS) begin
            mst_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            mst_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_mtie <= 1'b0;
            mie_meie <= 1'b0;
            mtvec    <= MTVEC_RST;
        end else if (wr_en) begin
            if (csr_addr == CSR_MIE) begin
                mie_mtie <= csr_wdata[MIE_MTIE_BIT];
                mie_meie <= csr_wdata[MIE_MEIE_BIT];
            end
            if (csr_addr == CSR_MTVEC)
                mtvec <= csr_wdata & ~XLEN'(2);
        end
    end

    // The interrupted instruction's own pc is saved so it re-executes after mret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc   <= '0;
            mcause <= '0;
        end else if (irq_take) begin
            mepc   <= pc & ALIGN4;
            mcause <= {1'b1, (XLEN-1)'(cause_code)};
        end else if (wr_en) begin
            if (csr_addr == CSR_MEPC)
                mepc <= csr_wdata & ALIGN4;
            if (csr_addr == CSR_MCAUSE)
                mcause <= csr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect   <= 1'b0;
            epc_target <= '0;
        end else begin
            redirect <= irq_take | mret_take;
            if (irq_take)
                epc_target <= trap_vec;
            else if (mret_take)
                epc_target <= mepc;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic
// compared against a behavioural model of the CSR/trap rules.
module tb_csr_file;

    localparam int          XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n, instr_valid, csr_rd, csr_wr, is_mret, timer_irq, ext_irq;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, pc, csr_rdata, epc_target;
    logic        redirect;

    int checks = 0;
    int errors = 0;

    csr_file #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .csr_rd(csr_rd),
        .csr_wr(csr_wr), .is_mret(is_mret), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .pc(pc), .timer_irq(timer_irq), .ext_irq(ext_irq), .csr_rdata(csr_rdata),
        .redirect(redirect), .epc_target(epc_target)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_gie, m_mpie, m_redirect;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_target;
    bit          m_t1, m_t2, m_e1, m_e2;
`ifdef CSR_MCYCLE_EN
    logic [63:0] m_cyc;
`endif

    task automatic model_reset();
        m_gie = 0; m_mpie = 0; m_redirect = 0;
        m_mie = 0; m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0; m_target = 0;
        m_t1 = 0; m_t2 = 0; m_e1 = 0; m_e2 = 0;
`ifdef CSR_MCYCLE_EN
        m_cyc = 0;
`endif
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_gie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (m_t2 ? 32'h80 : 32'h0) + (m_e2 ? 32'h800 : 32'h0);
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Applies one clock edge of architectural rules using the inputs held before it.
    task automatic model_step();
        bit pe, pt, take, dm, wr_ok;
        int code;
        pe    = m_mie[11] && m_e2;
        pt    = m_mie[7] && m_t2;
        take  = m_gie && (pe || pt) && instr_valid && !is_mret;
        dm    = instr_valid && is_mret;
        wr_ok = instr_valid && csr_wr && !take;
        m_redirect = take || dm;
        if (take) begin
            code     = pe ? 11 : 7;
            m_target = (m_mtvec & ~32'd3) + (m_mtvec[0] ? 32'(4 * code) : 32'd0);
            m_mepc   = pc & ~32'd3;
            m_mcause = 32'h8000_0000 + 32'(code);
            m_mpie   = m_gie;
            m_gie    = 0;
        end else begin
            if (dm) begin
                m_target = m_mepc;
                m_gie    = m_mpie;
                m_mpie   = 1;
            end
            if (wr_ok) begin
                case (csr_addr)
                    12'h300: if (!dm) begin m_gie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: m_mie = csr_wdata & 32'h880;
                    12'h305: m_mtvec = csr_wdata & ~32'd2;
                    12'h341: m_mepc = csr_wdata & ~32'd3;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
        end
`ifdef CSR_MCYCLE_EN
        if (wr_ok && csr_addr == 12'hB00)      m_cyc = {m_cyc[63:32], csr_wdata};
        else if (wr_ok && csr_addr == 12'hB80) m_cyc = {csr_wdata, m_cyc[31:0]};
        else                                   m_cyc = m_cyc + 64'd1;
`endif
        m_t2 = m_t1; m_t1 = timer_irq;
        m_e2 = m_e1; m_e1 = ext_irq;
    endtask

    task automatic set_in(input bit v, input bit rd, input bit wr, input bit mret,
                          input logic [11:0] a, input logic [31:0] wd, input logic [31:0] p);
        instr_valid = v; csr_rd = rd; csr_wr = wr; is_mret = mret;
        csr_addr = a; csr_wdata = wd; pc = p;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        set_in(1, 0, 1, 0, a, d, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        set_in(0, 1, 0, 0, 12'h305, 0, 0); #2;
        checks++; if (csr_rdata !== MTVEC_RST) begin errors++; $display("FAIL reset_mtvec got=%h exp=%h", csr_rdata, MTVEC_RST); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mstatus got=%h exp=0", csr_rdata); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mcause got=%h exp=0", csr_rdata); end
        checks++; if (redirect !== 1'b0 || epc_target !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect, epc_target); end
        csr_rd = 0; csr_addr = 12'h305; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rd_disabled got=%h exp=0", csr_rdata); end
    endtask

    task automatic test_write_read();
        set_in(1, 1, 1, 0, 12'h305, 32'h0000_1003, 0); #2;
        checks++; if (csr_rdata !== MTVEC_RST) begin errors++; $display("FAIL wr_same_cycle_old got=%h exp=%h", csr_rdata, MTVEC_RST); end
        tick();
        set_in(0, 1, 0, 0, 12'h305, 0, 0); #2;
        checks++; if (csr_rdata !== 32'h0000_1001) begin errors++; $display("FAIL mtvec_mode_mask got=%h exp=00001001", csr_rdata); end
        wr_csr(12'h344, 32'hFFFF_FFFF);
        wr_csr(12'h341, 32'hFFFF_FFFF);
        set_in(0, 1, 1, 0, 12'h304, 32'hFFFF_FFFF, 0); tick();   // bubble: no write
        csr_addr = 12'h344; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mip_readonly got=%h exp=0", csr_rdata); end
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mepc_align got=%h exp=fffffffc", csr_rdata); end
        csr_addr = 12'h304; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL bubble_no_write got=%h exp=0", csr_rdata); end
        csr_addr = 12'h7C0; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL unimpl_read got=%h exp=0", csr_rdata); end
    endtask

    task automatic test_timer_direct();
        wr_csr(12'h305, 32'h100);
        wr_csr(12'h304, 32'h80);
        wr_csr(12'h300, 32'h8);
        timer_irq = 1;
        set_in(0, 1, 0, 0, 12'h344, 0, 0); tick();
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mip_one_cycle got=%h exp=0", csr_rdata); end
        tick();
        checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL mip_two_cycles got=%h exp=80", csr_rdata); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL bubble_no_take got=%b exp=0", redirect); end
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h40); tick();
        checks++; if (redirect !== 1'b1 || epc_target !== 32'h100) begin errors++; $display("FAIL timer_redirect got=%b/%h exp=1/00000100", redirect, epc_target); end
        set_in(0, 1, 0, 0, 12'h341, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL timer_mepc got=%h exp=40", csr_rdata); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL timer_mcause got=%h exp=80000007", csr_rdata); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL timer_mstatus got=%h exp=80", csr_rdata); end
        tick();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL redirect_one_pulse got=%b exp=0", redirect); end
        timer_irq = 0;
    endtask

    task automatic test_vectored();
        wr_csr(12'h305, 32'h201);
        wr_csr(12'h304, 32'h880);
        timer_irq = 1; ext_irq = 1;
        set_in(0, 0, 0, 0, 12'h0, 0, 0); tick(); tick();
        wr_csr(12'h300, 32'h8);
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mie_write_no_same_take got=%b exp=0", redirect); end
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h40); tick();
        checks++; if (redirect !== 1'b1 || epc_target !== 32'h22C) begin errors++; $display("FAIL vec_redirect got=%b/%h exp=1/0000022c", redirect, epc_target); end
        set_in(0, 1, 0, 0, 12'h342, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL vec_mcause got=%h exp=8000000b", csr_rdata); end
        tick();
    endtask

    task automatic test_mret();
        set_in(1, 0, 0, 1, 12'h0, 0, 32'h99); tick();
        checks++; if (redirect !== 1'b1 || epc_target !== 32'h40) begin errors++; $display("FAIL mret_redirect got=%b/%h exp=1/00000040", redirect, epc_target); end
        set_in(0, 1, 0, 0, 12'h300, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h exp=88", csr_rdata); end
        tick();
        set_in(1, 0, 0, 1, 12'h0, 0, 32'h60); tick();
        checks++; if (redirect !== 1'b1 || epc_target !== 32'h40) begin errors++; $display("FAIL mret_wins_redirect got=%b/%h exp=1/00000040", redirect, epc_target); end
        set_in(0, 1, 0, 0, 12'h300, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_wins_no_take got=%h exp=88", csr_rdata); end
        tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h44); tick();
        checks++; if (redirect !== 1'b1 || epc_target !== 32'h22C) begin errors++; $display("FAIL take_after_mret got=%b/%h exp=1/0000022c", redirect, epc_target); end
        set_in(0, 1, 0, 0, 12'h341, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h44) begin errors++; $display("FAIL take_after_mret_mepc got=%h exp=44", csr_rdata); end
        timer_irq = 0; ext_irq = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_mcycle();
`ifdef CSR_MCYCLE_EN
        logic [31:0] lo;
        wr_csr(12'hB00, 32'hFFFF_FFFE);
        set_in(0, 1, 0, 0, 12'hB80, 0, 0); tick(); tick(); tick();
        checks++; if (csr_rdata !== 32'h1 || csr_rdata !== model_read(12'hB80)) begin errors++; $display("FAIL mcycle_carry_hi got=%h exp=1", csr_rdata); end
        csr_addr = 12'hB00; #1;
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycle_lo got=%h exp=1", csr_rdata); end
        set_in(1, 1, 1, 0, 12'hB00, 0, 0); #1;
        lo = csr_rdata;
        set_in(1, 1, 1, 0, 12'hB80, 32'h5, 0); tick();
        set_in(0, 1, 0, 0, 12'hB80, 0, 0); #1;
        checks++; if (csr_rdata !== 32'h5) begin errors++; $display("FAIL mcycleh_write got=%h exp=5", csr_rdata); end
        csr_addr = 12'hB00; #1;
        checks++; if (csr_rdata !== lo) begin errors++; $display("FAIL mcycle_lo_hold got=%h exp=%h", csr_rdata, lo); end
`else
        wr_csr(12'hB00, 32'h1234_5678);
        set_in(0, 1, 0, 0, 12'hB00, 0, 0); tick();
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_absent_lo got=%h exp=0", csr_rdata); end
        csr_addr = 12'hB80; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_absent_hi got=%h exp=0", csr_rdata); end
`endif
    endtask

    task automatic test_async_reset();
        wr_csr(12'h304, 32'h80);
        wr_csr(12'h300, 32'h8);
        timer_irq = 1;
        set_in(0, 0, 0, 0, 12'h0, 0, 0); tick(); tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h70); tick();
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL pre_reset_redirect got=%b exp=1", redirect); end
        set_in(0, 1, 0, 0, 12'h305, 0, 0);
        #1 rst_n = 0;
        #1;
        checks++; if (redirect !== 1'b0 || epc_target !== 32'h0) begin errors++; $display("FAIL async_reset_redirect got=%b/%h exp=0/0", redirect, epc_target); end
        checks++; if (csr_rdata !== MTVEC_RST) begin errors++; $display("FAIL async_reset_mtvec got=%h exp=%h", csr_rdata, MTVEC_RST); end
        timer_irq = 0;
        model_reset();
        @(posedge clk); #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_random();
        logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                    12'h344, 12'hB00, 12'hB80, 12'h301, 12'hF14};
        logic [31:0] exp;
        bit v, rd, wr, mr;
        logic [11:0] a;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            rd = $urandom_range(0, 1);
            mr = ($urandom_range(0, 15) == 0);
            wr = mr ? 1'b0 : 1'(($urandom_range(0, 2) == 0));
            a  = addrs[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
            set_in(v, rd, wr, mr, a, $urandom, $urandom);
            #2;
            exp = rd ? model_read(a) : 32'h0;
            checks++; if (csr_rdata !== exp) begin errors++; $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", i, a, csr_rdata, exp); end
            tick();
            checks++; if (redirect !== m_redirect) begin errors++; $display("FAIL rand_redirect[%0d] got=%b exp=%b", i, redirect, m_redirect); end
            if (m_redirect) begin
                checks++; if (epc_target !== m_target) begin errors++; $display("FAIL rand_target[%0d] got=%h exp=%h", i, epc_target, m_target); end
            end
        end
    endtask

    initial begin
        rst_n = 0; timer_irq = 0; ext_irq = 0;
        set_in(0, 0, 0, 0, 12'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        test_reset();
        test_write_read();
        test_timer_direct();
        test_vectored();
        test_mret();
        test_mcycle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
